// File: rtl/hdc_pkg.sv
// Shared constants, state encoding and character tokenizer for the HDC ham/spam classifier sequencer.
package hdc_pkg;

    localparam int DEF_DIM      = 1024;
    localparam int DEF_CHUNK_W  = 64;
    localparam int DEF_NUM_CHAR = 37;
    localparam int DEF_MAX_LEN  = 160;

    localparam int TOK_W = $clog2(DEF_NUM_CHAR);

    localparam logic [TOK_W-1:0] TOK_OTHER      = TOK_W'(0);
    localparam logic [TOK_W-1:0] TOK_DIGIT_BASE = TOK_W'(1);
    localparam logic [TOK_W-1:0] TOK_ALPHA_BASE = TOK_W'(11);

    localparam logic signed [1:0] RES_HAM  = 2'sb01;
    localparam logic signed [1:0] RES_SPAM = 2'sb11;
    localparam logic signed [1:0] RES_TIE  = 2'sb00;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACCUM    = 3'd1,
        ST_FLUSH    = 3'd2,
        ST_THR_WAIT = 3'd3,
        ST_COMPARE  = 3'd4,
        ST_DRAIN    = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    // Upper case folds onto lower case before the letter/digit/other split.
    function automatic logic [TOK_W-1:0] tokenize(input logic [7:0] ch);
        logic [7:0] c;
        c = (ch >= 8'h41 && ch <= 8'h5A) ? (ch | 8'h20) : ch;
        if (c >= 8'h61 && c <= 8'h7A) begin
            tokenize = TOK_W'(c - 8'h61) + TOK_ALPHA_BASE;
        end else if (c >= 8'h30 && c <= 8'h39) begin
            tokenize = TOK_W'(c - 8'h30) + TOK_DIGIT_BASE;
        end else begin
            tokenize = TOK_OTHER;
        end
    endfunction

endpackage

// File: rtl/hdc_popcount.sv
// Combinational population count of one compared chunk.
module hdc_popcount #(
    parameter int  W  = 64,
    localparam int OW = $clog2(W + 1)
) (
    input  logic [W-1:0]  din,
    output logic [OW-1:0] cnt
);

    // Ripple sum of all bits; synthesis rebalances into an adder tree.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < W; i++) begin
            cnt = cnt + OW'(din[i]);
        end
    end

endmodule

// File: rtl/hdc_classify_ctrl.sv
// Sequencer: tokenizes and bundles a message, triggers thresholding, then streams
// query/class chunks and reports the Hamming-distance verdict.
module hdc_classify_ctrl
    import hdc_pkg::*;
#(
    parameter int  DIM     = DEF_DIM,
    parameter int  CHUNK_W = DEF_CHUNK_W,
    parameter int  MAX_LEN = DEF_MAX_LEN,
    localparam int N_CHUNK = DIM / CHUNK_W,
    localparam int AW      = $clog2(N_CHUNK),
    localparam int CW      = $clog2(DIM + 1),
    localparam int LW      = $clog2(MAX_LEN + 1),
    localparam int PW      = $clog2(CHUNK_W + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [7:0]          s_char,
    input  logic                s_last,
    output logic [TOK_W-1:0]    im_addr,
    output logic                acc_en,
    output logic                acc_clr,
    output logic [LW-1:0]       n_chars,
    output logic                thr_go,
    input  logic                thr_done,
    output logic                rd_en,
    output logic [AW-1:0]       rd_addr,
    input  logic [CHUNK_W-1:0]  q_word,
    input  logic [CHUNK_W-1:0]  ham_word,
    input  logic [CHUNK_W-1:0]  spam_word,
    output logic                res_valid,
    input  logic                res_ready,
    output logic signed [1:0]   result,
    output logic [CW-1:0]       count_ham,
    output logic [CW-1:0]       count_spam,
    output logic                len_err,
    output logic                busy
);

    state_t            state, state_nxt;
    logic [TOK_W-1:0]  im_addr_nxt;
    logic              acc_en_nxt, acc_clr_nxt, thr_go_nxt, rd_en_nxt, res_valid_nxt, len_err_nxt;
    logic [LW-1:0]     n_chars_nxt;
    logic [AW-1:0]     rd_addr_nxt;
    logic              rd_dv;
    logic [CW-1:0]     count_ham_nxt, count_spam_nxt;
    logic signed [1:0] result_nxt;
    logic [PW-1:0]     pc_ham, pc_spam;
    logic [TOK_W-1:0]  tok;

    hdc_popcount #(.W(CHUNK_W)) u_pc_ham  (.din(q_word ^ ham_word),  .cnt(pc_ham));
    hdc_popcount #(.W(CHUNK_W)) u_pc_spam (.din(q_word ^ spam_word), .cnt(pc_spam));

    function automatic logic signed [1:0] verdict(input logic [CW-1:0] ch, input logic [CW-1:0] cs);
        if (ch < cs) begin
            verdict = RES_HAM;
        end else if (ch > cs) begin
            verdict = RES_SPAM;
        end else begin
            verdict = RES_TIE;
        end
    endfunction

    assign tok     = tokenize(s_char);
    assign s_ready = (state == ST_IDLE) || (state == ST_ACCUM);
    assign busy    = (state != ST_IDLE);

    // Next-state and next-output decode; pulses default low, held values default to current.
    always_comb begin
        state_nxt      = state;
        im_addr_nxt    = im_addr;
        acc_en_nxt     = 1'b0;
        acc_clr_nxt    = 1'b0;
        thr_go_nxt     = 1'b0;
        rd_en_nxt      = 1'b0;
        rd_addr_nxt    = rd_addr;
        n_chars_nxt    = n_chars;
        len_err_nxt    = len_err;
        res_valid_nxt  = res_valid;
        result_nxt     = result;
        // The chunk read in the previous cycle is folded in whenever its data is on the bus.
        count_ham_nxt  = rd_dv ? count_ham  + CW'(pc_ham)  : count_ham;
        count_spam_nxt = rd_dv ? count_spam + CW'(pc_spam) : count_spam;
        case (state)
            ST_IDLE: begin
                if (s_valid) begin
                    acc_en_nxt     = 1'b1;
                    acc_clr_nxt    = 1'b1;
                    im_addr_nxt    = tok;
                    n_chars_nxt    = LW'(1);
                    len_err_nxt    = 1'b0;
                    count_ham_nxt  = '0;
                    count_spam_nxt = '0;
                    state_nxt      = s_last ? ST_FLUSH : ST_ACCUM;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (s_valid) begin
                    if (n_chars < LW'(MAX_LEN)) begin
                        acc_en_nxt  = 1'b1;
                        im_addr_nxt = tok;
                        n_chars_nxt = n_chars + LW'(1);
                    end else begin
                        len_err_nxt = 1'b1;
                    end
                    state_nxt = s_last ? ST_FLUSH : ST_ACCUM;
                end else begin
                    state_nxt = ST_ACCUM;
                end
            end
            ST_FLUSH: begin
                thr_go_nxt = 1'b1;
                state_nxt  = ST_THR_WAIT;
            end
            ST_THR_WAIT: begin
                if (thr_done) begin
                    rd_en_nxt   = 1'b1;
                    rd_addr_nxt = '0;
                    state_nxt   = ST_COMPARE;
                end else begin
                    state_nxt = ST_THR_WAIT;
                end
            end
            ST_COMPARE: begin
                if (rd_addr == AW'(N_CHUNK - 1)) begin
                    state_nxt = ST_DRAIN;
                end else begin
                    rd_en_nxt   = 1'b1;
                    rd_addr_nxt = rd_addr + AW'(1);
                end
            end
            ST_DRAIN: begin
                res_valid_nxt = 1'b1;
                result_nxt    = verdict(count_ham_nxt, count_spam_nxt);
                state_nxt     = ST_DONE;
            end
            ST_DONE: begin
                if (res_ready) begin
                    res_valid_nxt = 1'b0;
                    state_nxt     = ST_IDLE;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops every pulse immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            im_addr    <= '0;
            acc_en     <= 1'b0;
            acc_clr    <= 1'b0;
            thr_go     <= 1'b0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            rd_dv      <= 1'b0;
            n_chars    <= '0;
            len_err    <= 1'b0;
            res_valid  <= 1'b0;
            result     <= RES_TIE;
            count_ham  <= '0;
            count_spam <= '0;
        end else begin
            state      <= state_nxt;
            im_addr    <= im_addr_nxt;
            acc_en     <= acc_en_nxt;
            acc_clr    <= acc_clr_nxt;
            thr_go     <= thr_go_nxt;
            rd_en      <= rd_en_nxt;
            rd_addr    <= rd_addr_nxt;
            rd_dv      <= rd_en;
            n_chars    <= n_chars_nxt;
            len_err    <= len_err_nxt;
            res_valid  <= res_valid_nxt;
            result     <= result_nxt;
            count_ham  <= count_ham_nxt;
            count_spam <= count_spam_nxt;
        end
    end

endmodule

// File: tb/tb_hdc_classify_ctrl.sv
// Randomized self-checking bench for hdc_classify_ctrl against a message-level reference model.
module tb_hdc_classify_ctrl;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               s_valid = 1'b0, s_last = 1'b0, thr_done = 1'b0, res_ready = 1'b0;
    logic [7:0]         s_char = 8'd0;
    logic               s_ready, acc_en, acc_clr, thr_go, rd_en, res_valid, len_err, busy;
    logic [5:0]         im_addr;
    logic [7:0]         n_chars;
    logic [3:0]         rd_addr;
    logic [63:0]        q_word = 64'd0, ham_word = 64'd0, spam_word = 64'd0;
    logic signed [1:0]  result;
    logic [10:0]        count_ham, count_spam;

    hdc_classify_ctrl dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_char(s_char), .s_last(s_last),
        .im_addr(im_addr), .acc_en(acc_en), .acc_clr(acc_clr), .n_chars(n_chars), .thr_go(thr_go),
        .thr_done(thr_done), .rd_en(rd_en), .rd_addr(rd_addr), .q_word(q_word), .ham_word(ham_word),
        .spam_word(spam_word), .res_valid(res_valid), .res_ready(res_ready), .result(result),
        .count_ham(count_ham), .count_spam(count_spam), .len_err(len_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Class/query memories with one-cycle read latency.
    logic [63:0] qm[16], hm[16], sm[16];
    always @(posedge clk) begin
        if (rd_en) begin
            q_word    <= qm[rd_addr];
            ham_word  <= hm[rd_addr];
            spam_word <= sm[rd_addr];
        end
    end

    int n_tests = 0, n_fail = 0;
    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_tok(input byte unsigned c);
        if (c >= 65 && c <= 90)  return int'(c) - 65 + 11;
        if (c >= 97 && c <= 122) return int'(c) - 97 + 11;
        if (c >= 48 && c <= 57)  return int'(c) - 48 + 1;
        return 0;
    endfunction

    // Expectations for the message in flight.
    int exp_tok[$];
    bit exp_clr[$];
    int log_tok[$];
    int exp_ham, exp_spam, exp_res, exp_n;
    bit exp_lerr;
    int t_done = -1;
    int thr_go_cnt, rd_cnt;
    bit res_seen;

    // Per-cycle compare against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (acc_en) begin
                log_tok.push_back(int'(im_addr));
                if (exp_tok.size() == 0) begin
                    chk("acc_en_extra", 1, 0);
                end else begin
                    chk("im_addr", im_addr, exp_tok.pop_front());
                    chk("acc_clr", acc_clr, exp_clr.pop_front());
                end
            end
            if (thr_go) thr_go_cnt++;
            if (rd_en) begin
                rd_cnt++;
                if (t_done < 0) chk("rd_en_unexpected", 1, 0);
                else            chk("rd_addr", rd_addr, cyc - t_done - 1);
            end
            if (res_valid && !res_seen) begin
                res_seen = 1'b1;
                chk("res_latency", cyc, t_done + 18);
                chk("count_ham", count_ham, exp_ham);
                chk("count_spam", count_spam, exp_spam);
                chk("result", result, exp_res);
            end
        end
    end

    task automatic prep(input byte unsigned msg[$]);
        int n;
        n = msg.size();
        exp_n = (n > 160) ? 160 : n;
        exp_lerr = (n > 160);
        exp_tok.delete(); exp_clr.delete(); log_tok.delete();
        for (int i = 0; i < exp_n; i++) begin
            exp_tok.push_back(model_tok(msg[i]));
            exp_clr.push_back(i == 0);
        end
        exp_ham = 0; exp_spam = 0;
        for (int i = 0; i < 16; i++) begin
            exp_ham  += $countones(qm[i] ^ hm[i]);
            exp_spam += $countones(qm[i] ^ sm[i]);
        end
        exp_res = (exp_ham < exp_spam) ? 1 : (exp_ham > exp_spam) ? -1 : 0;
        thr_go_cnt = 0; rd_cnt = 0; res_seen = 1'b0; t_done = -1;
    endtask

    // Drives all beats, waits for thr_go and answers with thr_done.
    task automatic drive(input byte unsigned msg[$]);
        int w;
        for (int i = 0; i < msg.size(); i++) begin
            s_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            s_valid = 1'b1; s_char = msg[i]; s_last = (i == msg.size() - 1);
            chk("s_ready_beat", s_ready, 1);
            @(posedge clk); #1;
        end
        s_valid = 1'b0; s_last = 1'b0;
        w = 0;
        while (thr_go_cnt == 0 && w < 20) begin @(posedge clk); #1; w++; end
        chk("thr_go_seen", thr_go_cnt > 0, 1);
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        thr_done = 1'b1; t_done = cyc;
        @(posedge clk); #1;
        thr_done = 1'b0;
    endtask

    task automatic run_msg(input byte unsigned msg[$], input int hold);
        int w;
        prep(msg);
        drive(msg);
        w = 0;
        while (!res_seen && w < 40) begin @(posedge clk); #1; w++; end
        chk("res_valid_seen", res_seen, 1);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", res_valid, 1);
            chk("hold_ham", count_ham, exp_ham);
            chk("hold_spam", count_spam, exp_spam);
            chk("hold_result", result, exp_res);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("res_valid_drop", res_valid, 0);
        chk("idle_after", busy, 0);
        chk("tok_left", exp_tok.size(), 0);
        chk("n_chars", n_chars, exp_n);
        chk("len_err", len_err, exp_lerr);
        chk("thr_go_cnt", thr_go_cnt, 1);
        chk("rd_cnt", rd_cnt, 16);
    endtask

    function automatic void fill_rand();
        for (int i = 0; i < 16; i++) begin
            qm[i] = {$urandom, $urandom};
            hm[i] = {$urandom, $urandom};
            sm[i] = {$urandom, $urandom};
        end
    endfunction

    function automatic void fill_const(input logic [63:0] q, input logic [63:0] h, input logic [63:0] s);
        for (int i = 0; i < 16; i++) begin
            qm[i] = q; hm[i] = h; sm[i] = s;
        end
    endfunction

    function automatic void rand_msg(output byte unsigned m[$], input int len);
        m.delete();
        for (int i = 0; i < len; i++) m.push_back(byte'($urandom_range(32, 126)));
    endfunction

    initial begin
        byte unsigned m[$];
        fill_const(64'd0, 64'd0, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {acc_en, acc_clr, thr_go, rd_en, res_valid}, 0);
        chk("rst_result", result, 0);
        chk("rst_counts", count_ham + count_spam, 0);
        chk("rst_n_chars", n_chars, 0);
        chk("rst_len_err", len_err, 0);

        // Spurious thr_done while idle must do nothing.
        @(posedge clk); #1 thr_done = 1'b1;
        @(posedge clk); #1 thr_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("spur_busy", busy, 0);
            chk("spur_rd_en", rd_en, 0);
        end
        @(posedge clk); #1;

        // "Ab9?" against q=ham=0, spam=all-1.
        fill_const(64'd0, 64'd0, '1);
        m = '{8'h41, 8'h62, 8'h39, 8'h3F};
        run_msg(m, 5);
        chk("lit_len", log_tok.size(), 4);
        chk("lit_tok0", log_tok[0], 11);
        chk("lit_tok1", log_tok[1], 12);
        chk("lit_tok2", log_tok[2], 10);
        chk("lit_tok3", log_tok[3], 0);
        chk("lit_n_chars", n_chars, 4);
        chk("lit_ham", count_ham, 0);
        chk("lit_spam", count_spam, 1024);
        chk("lit_result", result, 1);

        // Swapped class words.
        fill_const(64'd0, '1, 64'd0);
        rand_msg(m, 7);
        run_msg(m, 1);
        chk("lit_swap_result", result, -1);
        chk("lit_swap_ham", count_ham, 1024);

        // 37 ones per class in different chunks -> tie.
        fill_const(64'd0, 64'd0, 64'd0);
        hm[2] = 64'h0000_001F_FFFF_FFFF;
        sm[9] = 64'h0000_001F_FFFF_FFFF << 20;
        rand_msg(m, 3);
        run_msg(m, 2);
        chk("lit_tie_ham", count_ham, 37);
        chk("lit_tie_spam", count_spam, 37);
        chk("lit_tie_result", result, 0);

        // Overlong message, then a normal one clears len_err.
        fill_rand();
        rand_msg(m, 165);
        run_msg(m, 0);
        chk("lit_long_n", n_chars, 160);
        chk("lit_long_err", len_err, 1);
        rand_msg(m, 5);
        run_msg(m, 0);
        chk("lit_clear_err", len_err, 0);

        // Single-beat message.
        fill_rand();
        m = '{8'h5A};
        run_msg(m, 0);

        // Randomized messages.
        for (int k = 0; k < 6; k++) begin
            fill_rand();
            rand_msg(m, $urandom_range(1, 40));
            run_msg(m, $urandom_range(0, 4));
        end

        // Reset in the middle of the chunk stream.
        fill_rand();
        rand_msg(m, 4);
        prep(m);
        drive(m);
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; t_done = -1;
        repeat (30) begin
            @(negedge clk);
            chk("abort_no_valid", res_valid, 0);
        end
        chk("abort_busy", busy, 0);
        chk("abort_s_ready", s_ready, 1);
        chk("abort_no_result", res_seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
